wca_wbf_arb: RTL and testbench
==============================

Name: wca_wbf_arb

Overview:
- Shares the single Weight Buffer read channel (address plus returned data) between NUM_REQ weight-cache instances, one per PE-row group.
- Arbitrates address requests round-robin with grant lock under backpressure.
- Records the granted requester in an in-order tag FIFO and steers each returned data beat back to that requester.
- Sits between the weight-cache read ports and the Weight Buffer; a config port sets which requesters are enabled.

Parameters:
- NUM_REQ, 4, number of weight-cache requesters.
- WEI_ADDR_WIDTH, 8, weight buffer address width.
- DATA_WIDTH, 8, weight data width.
- MAX_OUTST, 4, maximum outstanding reads; tag FIFO depth, power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- TOPARB_CfgVld  in  1  load requester enable mask
- TOPARB_CfgMsk  in  NUM_REQ  enable mask; bit i = requester i enabled
- ARBTOP_CfgRdy  out  1  high when no reads are outstanding and no grant is locked
- WCAARB_AdrVld  in  NUM_REQ  per-requester address valid
- WCAARB_Adr  in  NUM_REQ x WEI_ADDR_WIDTH  per-requester address
- ARBWCA_AdrRdy  out  NUM_REQ  per-requester address ready
- ARBWCA_DatVld  out  NUM_REQ  per-requester data valid
- ARBWCA_Dat  out  NUM_REQ x DATA_WIDTH  data, same bus broadcast to all requesters
- WCAARB_DatRdy  in  NUM_REQ  per-requester data ready
- ARBWBF_AdrVld  out  1  address valid to Weight Buffer
- ARBWBF_Adr  out  WEI_ADDR_WIDTH  address to Weight Buffer
- WBFARB_AdrRdy  in  1  Weight Buffer address ready
- WBFARB_DatVld  in  1  Weight Buffer data valid
- WBFARB_Dat  in  DATA_WIDTH  Weight Buffer data
- ARBWBF_DatRdy  out  1  data ready to Weight Buffer
- ARBTOP_Err  out  1  sticky: data arrived while the tag FIFO was empty

Behaviour:
- Reset (rst sampled high at a clk edge):
  - mask = all ones; rr_ptr = 0; lock = 0; FIFO wr_ptr = rd_ptr = count = 0; Err = 0.
  - All outputs are 0 except ARBTOP_CfgRdy = 1.
  - Reset mid-operation discards all outstanding tags; data returned afterwards raises Err.
- Eligible requests: req = WCAARB_AdrVld & mask.
- Grant:
  - If lock = 1, gnt = lock_id.
  - Otherwise gnt = first set bit of req, searching cyclically from rr_ptr upward and wrapping at NUM_REQ-1 back to 0.
- Address channel:
  - ARBWBF_AdrVld = |req & !full.
  - ARBWBF_Adr = WCAARB_Adr[gnt], or 0 when not valid.
  - ARBWCA_AdrRdy[i] = (i == gnt) & ARBWBF_AdrVld & WBFARB_AdrRdy.
  - Address path is combinational, zero latency.
- Lock:
  - If ARBWBF_AdrVld & !WBFARB_AdrRdy: lock <= 1 and lock_id <= gnt. The grant cannot migrate while downstream stalls.
  - On address handshake: lock <= 0, rr_ptr <= (gnt+1) mod NUM_REQ, tag gnt pushed into the FIFO.
- FIFO full (count == MAX_OUTST):
  - ARBWBF_AdrVld is forced low, even if a pop happens in the same cycle (no bypass).
  - The lock is held.
- Data channel:
  - head = FIFO[rd_ptr].
  - ARBWBF_DatRdy = !empty & WCAARB_DatRdy[head].
  - ARBWCA_DatVld[i] = !empty & WBFARB_DatVld & (i == head).
  - ARBWCA_Dat = WBFARB_Dat, combinational.
  - Pop when WBFARB_DatVld & ARBWBF_DatRdy.
- Simultaneous push and pop: count is unchanged; both pointers advance, modulo MAX_OUTST.
- Empty FIFO with WBFARB_DatVld = 1: DatRdy stays 0 and Err <= 1. Err clears only on rst.
- Config:
  - When TOPARB_CfgVld & ARBTOP_CfgRdy: mask <= TOPARB_CfgMsk and rr_ptr <= 0.
  - TOPARB_CfgVld while CfgRdy = 0 is ignored.
  - A masked requester never receives AdrRdy; its outstanding data is still delivered.
- Responses are strictly in order; the Weight Buffer channel is in-order.

Decomposition:
- Shared package: typedef for the requester id (width $clog2(NUM_REQ)), and the default parameter values.
- Sub-module: wca_tag_fifo, a synchronous FIFO of requester ids with push, pop, full, empty and count, depth MAX_OUTST.
- Round-robin selection logic stays in the top level as a function.

Test Plan:
- Reset, then requesters 0 and 2 both valid with addresses 0x10/0x20, AdrRdy always 1 -> ARBWBF_Adr sequence 0x10, 0x20, 0x10…; requester 1 never granted.
- Requester 1 valid with 0x33, WBFARB_AdrRdy = 0 for 3 cycles, requester 0 becomes valid in cycle 2 -> ARBWBF_Adr stays 0x33 and gnt stays 1 until the handshake; requester 0 is served next.
- 4 address handshakes with no data return -> 5th ARBWBF_AdrVld = 0 (full); one data beat returns -> head requester's DatVld = 1, and the next cycle AdrVld = 1.
- Tags 3,1 outstanding; data 0xAA, then 0xBB with WCAARB_DatRdy[3] = 0 for 2 cycles -> ARBWBF_DatRdy = 0 for 2 cycles; 0xAA goes to port 3, 0xBB to port 1.
- WBFARB_DatVld = 1 with FIFO empty -> ARBTOP_Err = 1 and stays 1 until rst; ARBWBF_DatRdy = 0.
- Cfg mask 4'b0100 while 1 read is outstanding -> ignored; after that read drains, cfg accepted; only requester 2 is granted. Assert rst mid-stream -> all state returns to its reset values on the next edge.

Source files
------------

// File: rtl/wca_wbf_arb_pkg.sv
// Shared types and default sizing for the weight-buffer read arbiter.
package wca_wbf_arb_pkg;

    localparam int NUM_REQ_DFLT        = 4;
    localparam int WEI_ADDR_WIDTH_DFLT = 8;
    localparam int DATA_WIDTH_DFLT     = 8;
    localparam int MAX_OUTST_DFLT      = 4;

    // Requester id; wide enough for the default requester count.
    // A NUM_REQ override must stay within 2**REQ_ID_W requesters.
    localparam int REQ_ID_W = $clog2(NUM_REQ_DFLT);
    typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/wca_wbf_arb_if.sv
// Bundle of config, weight-cache and weight-buffer channels around the arbiter.
interface wca_wbf_arb_if
    import wca_wbf_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DFLT,
    parameter int WEI_ADDR_WIDTH = WEI_ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DFLT
) ();

    logic                                        TOPARB_CfgVld;
    logic [NUM_REQ-1:0]                          TOPARB_CfgMsk;
    logic                                        ARBTOP_CfgRdy;
    logic                                        ARBTOP_Err;

    logic [NUM_REQ-1:0]                          WCAARB_AdrVld;
    logic [NUM_REQ-1:0][WEI_ADDR_WIDTH-1:0]      WCAARB_Adr;
    logic [NUM_REQ-1:0]                          ARBWCA_AdrRdy;
    logic [NUM_REQ-1:0]                          ARBWCA_DatVld;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]          ARBWCA_Dat;
    logic [NUM_REQ-1:0]                          WCAARB_DatRdy;

    logic                                        ARBWBF_AdrVld;
    logic [WEI_ADDR_WIDTH-1:0]                   ARBWBF_Adr;
    logic                                        WBFARB_AdrRdy;
    logic                                        WBFARB_DatVld;
    logic [DATA_WIDTH-1:0]                       WBFARB_Dat;
    logic                                        ARBWBF_DatRdy;

    // Arbiter side.
    modport slave (
        input  TOPARB_CfgVld, TOPARB_CfgMsk,
        output ARBTOP_CfgRdy, ARBTOP_Err,
        input  WCAARB_AdrVld, WCAARB_Adr, WCAARB_DatRdy,
        output ARBWCA_AdrRdy, ARBWCA_DatVld, ARBWCA_Dat,
        output ARBWBF_AdrVld, ARBWBF_Adr, ARBWBF_DatRdy,
        input  WBFARB_AdrRdy, WBFARB_DatVld, WBFARB_Dat
    );

    // Surrounding system side (caches, weight buffer, top control).
    modport master (
        output TOPARB_CfgVld, TOPARB_CfgMsk,
        input  ARBTOP_CfgRdy, ARBTOP_Err,
        output WCAARB_AdrVld, WCAARB_Adr, WCAARB_DatRdy,
        input  ARBWCA_AdrRdy, ARBWCA_DatVld, ARBWCA_Dat,
        input  ARBWBF_AdrVld, ARBWBF_Adr, ARBWBF_DatRdy,
        output WBFARB_AdrRdy, WBFARB_DatVld, WBFARB_Dat
    );

endinterface

// File: rtl/wca_tag_fifo.sv
// In-order FIFO of requester ids, one entry per outstanding weight read.
module wca_tag_fifo
    import wca_wbf_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTST_DFLT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  req_id_t                i_push_id,
    input  logic                   i_pop,
    output req_id_t                o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               w_push_en;
    logic               w_pop_en;

    assign o_full    = (r_count == PTR_W'(0) + (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // The head must be visible in the same cycle a data beat arrives.
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_en = i_push & ~o_full;
    assign w_pop_en  = i_pop & ~o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W+1)'(w_push_en) - (PTR_W+1)'(w_pop_en);
        end
    end

    // Storage has no reset; stale entries are never read while empty.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr] <= i_push_id;
    end

endmodule

// File: rtl/wca_wbf_arb.sv
// Round-robin arbiter sharing one Weight Buffer read channel between
// weight-cache requesters, with in-order steering of returned data.
module wca_wbf_arb
    import wca_wbf_arb_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DFLT,
    parameter int WEI_ADDR_WIDTH = WEI_ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH     = DATA_WIDTH_DFLT,
    parameter int MAX_OUTST      = MAX_OUTST_DFLT
) (
    input  logic          clk,
    input  logic          rst,
    wca_wbf_arb_if.slave  io_bus
);

    logic [NUM_REQ-1:0]          r_mask;
    req_id_t                     r_rr_ptr;
    logic                        r_lock;
    req_id_t                     r_lock_id;
    logic                        r_err;

    logic [NUM_REQ-1:0]          w_req;
    logic [NUM_REQ-1:0]          w_adr_rdy;
    logic [NUM_REQ-1:0]          w_dat_vld;
    req_id_t                     w_gnt;
    req_id_t                     w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(MAX_OUTST):0]  w_count;
    logic                        w_adr_vld;
    logic                        w_adr_hs;
    logic                        w_dat_rdy;
    logic                        w_pop;
    logic                        w_cfg_rdy;
    logic                        w_cfg_acc;

    // First set bit of req at or cyclically after ptr; lowest offset wins.
    function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] req,
                                        input req_id_t ptr);
        req_id_t pick;
        int      idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) pick = req_id_t'(idx);
        end
        return pick;
    endfunction

    assign w_req     = io_bus.WCAARB_AdrVld & r_mask;
    assign w_gnt     = r_lock ? r_lock_id : rr_pick(w_req, r_rr_ptr);
    // Full blocks issue even if a pop happens this cycle: no bypass path.
    assign w_adr_vld = (|w_req) & ~w_full;
    assign w_adr_hs  = w_adr_vld & io_bus.WBFARB_AdrRdy;
    assign w_dat_rdy = ~w_empty & io_bus.WCAARB_DatRdy[w_head];
    assign w_pop     = io_bus.WBFARB_DatVld & w_dat_rdy;
    assign w_cfg_rdy = (w_count == '0) & ~r_lock;
    assign w_cfg_acc = io_bus.TOPARB_CfgVld & w_cfg_rdy;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_adr_rdy[gi] = w_adr_hs & (w_gnt == req_id_t'(gi));
            assign w_dat_vld[gi] = ~w_empty & io_bus.WBFARB_DatVld &
                                   (w_head == req_id_t'(gi));
        end
    endgenerate

    assign io_bus.ARBWBF_AdrVld = w_adr_vld;
    assign io_bus.ARBWBF_Adr    = w_adr_vld ? io_bus.WCAARB_Adr[w_gnt] : '0;
    assign io_bus.ARBWCA_AdrRdy = w_adr_rdy;
    assign io_bus.ARBWCA_DatVld = w_dat_vld;
    assign io_bus.ARBWCA_Dat    = {NUM_REQ{io_bus.WBFARB_Dat}};
    assign io_bus.ARBWBF_DatRdy = w_dat_rdy;
    assign io_bus.ARBTOP_CfgRdy = w_cfg_rdy;
    assign io_bus.ARBTOP_Err    = r_err;

    wca_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_adr_hs),
        .i_push_id (w_gnt),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // Grant lock: pin the grant while the Weight Buffer stalls an offered
    // address; a full FIFO leaves the lock untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_adr_hs) begin
            r_lock    <= 1'b0;
        end else if (w_adr_vld) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt;
        end
    end

    // Round-robin pointer and enable mask; a config load restarts at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask   <= '1;
            r_rr_ptr <= '0;
        end else if (w_cfg_acc) begin
            r_mask   <= io_bus.TOPARB_CfgMsk;
            r_rr_ptr <= '0;
        end else if (w_adr_hs) begin
            r_rr_ptr <= (w_gnt == req_id_t'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        end
    end

    // Sticky error: data returned with no outstanding tag to steer it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (io_bus.WBFARB_DatVld & w_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wca_wbf_arb.sv
// Directed bench for wca_wbf_arb with address and data scoreboards.
module tb_wca_wbf_arb;
    import wca_wbf_arb_pkg::*;

    typedef struct {
        int         port;
        logic [7:0] dat;
    } beat_t;

    logic clk;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] q_adr [$];
    beat_t      q_dat [$];

    wca_wbf_arb_if #(.NUM_REQ(4), .WEI_ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    wca_wbf_arb #(.NUM_REQ(4), .WEI_ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTST(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_sample();
        @(negedge clk);
        #1;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int port, input logic [7:0] dat);
        beat_t b;
        b.port = port;
        b.dat  = dat;
        q_dat.push_back(b);
    endtask

    // Scoreboard: every handshake pops the next expected address / beat.
    always @(negedge clk) begin
        logic [7:0] e;
        beat_t      b;
        if (!rst && bus.ARBWBF_AdrVld && bus.WBFARB_AdrRdy) begin
            chk("adr_pending", 32'(q_adr.size() > 0), 32'h1);
            if (q_adr.size() > 0) begin
                e = q_adr.pop_front();
                chk("adr_hs", 32'(bus.ARBWBF_Adr), 32'(e));
                $display("adr handshake adr=%0h exp=%0h", bus.ARBWBF_Adr, e);
            end
        end
        if (!rst && bus.WBFARB_DatVld && bus.ARBWBF_DatRdy) begin
            chk("dat_pending", 32'(q_dat.size() > 0), 32'h1);
            if (q_dat.size() > 0) begin
                b = q_dat.pop_front();
                chk("dat_port", 32'(bus.ARBWCA_DatVld), 32'(1) << b.port);
                chk("dat_val", 32'(bus.ARBWCA_Dat[b.port]), 32'(b.dat));
                $display("dat handshake vld=%b dat=%0h exp_port=%0d exp_dat=%0h",
                         bus.ARBWCA_DatVld, bus.ARBWCA_Dat[b.port], b.port, b.dat);
            end
        end
    end

    initial begin
        rst               = 1'b1;
        bus.TOPARB_CfgVld = 1'b0;
        bus.TOPARB_CfgMsk = '0;
        bus.WCAARB_AdrVld = '0;
        bus.WCAARB_Adr    = '0;
        bus.WCAARB_DatRdy = '0;
        bus.WBFARB_AdrRdy = 1'b0;
        bus.WBFARB_DatVld = 1'b0;
        bus.WBFARB_Dat    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        to_sample();
        chk("rst_cfgrdy", 32'(bus.ARBTOP_CfgRdy), 32'h1);
        chk("rst_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h0);
        chk("rst_adr", 32'(bus.ARBWBF_Adr), 32'h0);
        chk("rst_adrrdy", 32'(bus.ARBWCA_AdrRdy), 32'h0);
        chk("rst_datvld", 32'(bus.ARBWCA_DatVld), 32'h0);
        chk("rst_datrdy", 32'(bus.ARBWBF_DatRdy), 32'h0);
        chk("rst_err", 32'(bus.ARBTOP_Err), 32'h0);
        to_drive();

        // Requesters 0 and 2 alternate; fill the FIFO with 4 reads
        bus.WCAARB_AdrVld = 4'b0101;
        bus.WCAARB_Adr[0] = 8'h10;
        bus.WCAARB_Adr[2] = 8'h20;
        bus.WBFARB_AdrRdy = 1'b1;
        bus.WCAARB_DatRdy = 4'hF;
        q_adr.push_back(8'h10); q_adr.push_back(8'h20);
        q_adr.push_back(8'h10); q_adr.push_back(8'h20);
        for (int i = 0; i < 4; i++) begin
            to_sample();
            chk("rr_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h1);
            chk("rr_req1_rdy", 32'(bus.ARBWCA_AdrRdy[1]), 32'h0);
            to_drive();
        end
        to_sample();
        chk("full_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h0);
        chk("full_cfgrdy", 32'(bus.ARBTOP_CfgRdy), 32'h0);
        to_drive();

        // One beat returns to head requester 0; no bypass while full
        bus.WBFARB_DatVld = 1'b1;
        bus.WBFARB_Dat    = 8'hA0;
        push_beat(0, 8'hA0);
        to_sample();
        chk("full_pop_datvld", 32'(bus.ARBWCA_DatVld), 32'h1);
        chk("full_pop_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h0);
        to_drive();
        bus.WBFARB_DatVld = 1'b0;
        q_adr.push_back(8'h10);
        to_sample();
        chk("after_pop_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h1);
        chk("after_pop_adr", 32'(bus.ARBWBF_Adr), 32'h10);
        to_drive();
        bus.WCAARB_AdrVld = '0;

        // Drain tags 2,0,2,0
        for (int i = 0; i < 4; i++) begin
            bus.WBFARB_DatVld = 1'b1;
            bus.WBFARB_Dat    = 8'hA1 + 8'(i);
            push_beat((i % 2 == 0) ? 2 : 0, 8'hA1 + 8'(i));
            to_sample();
            to_drive();
        end
        bus.WBFARB_DatVld = 1'b0;

        // Reload full mask to restart the pointer at 0
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'hF;
        to_sample();
        chk("cfg1_rdy", 32'(bus.ARBTOP_CfgRdy), 32'h1);
        to_drive();
        bus.TOPARB_CfgVld = 1'b0;

        // Lock under backpressure: requester 1 held while 0 joins
        bus.WCAARB_AdrVld = 4'b0010;
        bus.WCAARB_Adr[1] = 8'h33;
        bus.WBFARB_AdrRdy = 1'b0;
        to_sample();
        chk("lock_c1_adr", 32'(bus.ARBWBF_Adr), 32'h33);
        chk("lock_c1_adrrdy", 32'(bus.ARBWCA_AdrRdy), 32'h0);
        to_drive();
        bus.WCAARB_AdrVld = 4'b0011;
        bus.WCAARB_Adr[0] = 8'h44;
        to_sample();
        chk("lock_c2_adr", 32'(bus.ARBWBF_Adr), 32'h33);
        chk("lock_c2_cfgrdy", 32'(bus.ARBTOP_CfgRdy), 32'h0);
        to_drive();
        to_sample();
        chk("lock_c3_adr", 32'(bus.ARBWBF_Adr), 32'h33);
        to_drive();
        bus.WBFARB_AdrRdy = 1'b1;
        q_adr.push_back(8'h33);
        to_sample();
        chk("lock_hs_rdy", 32'(bus.ARBWCA_AdrRdy), 32'h2);
        to_drive();
        q_adr.push_back(8'h44);
        to_sample();
        chk("lock_next_rdy", 32'(bus.ARBWCA_AdrRdy), 32'h1);
        to_drive();
        bus.WCAARB_AdrVld = '0;
        bus.WBFARB_DatVld = 1'b1;
        bus.WBFARB_Dat    = 8'hB1;
        push_beat(1, 8'hB1);
        to_sample();
        to_drive();
        bus.WBFARB_Dat    = 8'hB2;
        push_beat(0, 8'hB2);
        to_sample();
        to_drive();
        bus.WBFARB_DatVld = 1'b0;

        // Tags 3 then 1 outstanding; head stalls on its data ready
        bus.WCAARB_AdrVld = 4'b1000;
        bus.WCAARB_Adr[3] = 8'h53;
        q_adr.push_back(8'h53);
        to_sample();
        chk("t3_adrrdy", 32'(bus.ARBWCA_AdrRdy), 32'h8);
        to_drive();
        bus.WCAARB_AdrVld = 4'b0010;
        bus.WCAARB_Adr[1] = 8'h51;
        q_adr.push_back(8'h51);
        to_sample();
        to_drive();
        bus.WCAARB_AdrVld = '0;
        bus.WBFARB_DatVld = 1'b1;
        bus.WBFARB_Dat    = 8'hAA;
        bus.WCAARB_DatRdy = 4'b0111;
        for (int i = 0; i < 2; i++) begin
            to_sample();
            chk("stall_datrdy", 32'(bus.ARBWBF_DatRdy), 32'h0);
            chk("stall_datvld", 32'(bus.ARBWCA_DatVld), 32'h8);
            to_drive();
        end
        bus.WCAARB_DatRdy = 4'hF;
        push_beat(3, 8'hAA);
        to_sample();
        to_drive();
        bus.WBFARB_Dat = 8'hBB;
        push_beat(1, 8'hBB);
        to_sample();
        to_drive();

        // Data with empty FIFO raises sticky error
        bus.WBFARB_Dat = 8'hCC;
        to_sample();
        chk("empty_datrdy", 32'(bus.ARBWBF_DatRdy), 32'h0);
        chk("empty_datvld", 32'(bus.ARBWCA_DatVld), 32'h0);
        chk("empty_err_pre", 32'(bus.ARBTOP_Err), 32'h0);
        to_drive();
        bus.WBFARB_DatVld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            to_sample();
            chk("err_sticky", 32'(bus.ARBTOP_Err), 32'h1);
            to_drive();
        end

        // Config ignored while a read is outstanding
        bus.WCAARB_AdrVld = 4'b0001;
        bus.WCAARB_Adr[0] = 8'h60;
        q_adr.push_back(8'h60);
        to_sample();
        to_drive();
        bus.WCAARB_AdrVld = '0;
        bus.TOPARB_CfgVld = 1'b1;
        bus.TOPARB_CfgMsk = 4'b0100;
        to_sample();
        chk("cfg_busy_rdy", 32'(bus.ARBTOP_CfgRdy), 32'h0);
        to_drive();
        bus.TOPARB_CfgVld = 1'b0;
        bus.WCAARB_AdrVld = 4'b0001;
        q_adr.push_back(8'h60);
        to_sample();
        chk("cfg_ignored_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h1);
        to_drive();
        bus.WCAARB_AdrVld = '0;
        bus.WBFARB_DatVld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.WBFARB_Dat = 8'hD0 + 8'(i);
            push_beat(0, 8'hD0 + 8'(i));
            to_sample();
            to_drive();
        end
        bus.WBFARB_DatVld = 1'b0;
        bus.TOPARB_CfgVld = 1'b1;
        to_sample();
        chk("cfg2_rdy", 32'(bus.ARBTOP_CfgRdy), 32'h1);
        to_drive();
        bus.TOPARB_CfgVld = 1'b0;
        bus.WCAARB_AdrVld = 4'b0111;
        bus.WCAARB_Adr[1] = 8'h61;
        bus.WCAARB_Adr[2] = 8'h62;
        q_adr.push_back(8'h62); q_adr.push_back(8'h62);
        for (int i = 0; i < 2; i++) begin
            to_sample();
            chk("mask_only2_rdy", 32'(bus.ARBWCA_AdrRdy), 32'h4);
            to_drive();
        end
        bus.WCAARB_AdrVld = 4'b0011;
        to_sample();
        chk("mask_blocked_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h0);
        to_drive();

        // Reset mid-stream with two reads outstanding
        rst               = 1'b1;
        bus.WCAARB_AdrVld = '0;
        bus.WBFARB_AdrRdy = 1'b0;
        bus.WCAARB_DatRdy = '0;
        to_drive();
        rst = 1'b0;
        to_sample();
        chk("rst2_cfgrdy", 32'(bus.ARBTOP_CfgRdy), 32'h1);
        chk("rst2_err", 32'(bus.ARBTOP_Err), 32'h0);
        chk("rst2_adrvld", 32'(bus.ARBWBF_AdrVld), 32'h0);
        chk("rst2_datrdy", 32'(bus.ARBWBF_DatRdy), 32'h0);
        to_drive();
        bus.WCAARB_DatRdy = 4'hF;
        bus.WBFARB_DatVld = 1'b1;
        bus.WBFARB_Dat    = 8'hEE;
        to_sample();
        chk("rst2_discard_datrdy", 32'(bus.ARBWBF_DatRdy), 32'h0);
        to_drive();
        bus.WBFARB_DatVld = 1'b0;
        to_sample();
        chk("rst2_discard_err", 32'(bus.ARBTOP_Err), 32'h1);
        to_drive();

        // Mask back to all ones and pointer back to 0
        bus.WBFARB_AdrRdy = 1'b1;
        bus.WCAARB_AdrVld = 4'b0011;
        q_adr.push_back(8'h60);
        to_sample();
        chk("rst2_adr", 32'(bus.ARBWBF_Adr), 32'h60);
        to_drive();
        bus.WCAARB_AdrVld = '0;
        bus.WBFARB_DatVld = 1'b1;
        bus.WBFARB_Dat    = 8'hF0;
        push_beat(0, 8'hF0);
        to_sample();
        to_drive();
        bus.WBFARB_DatVld = 1'b0;
        to_sample();

        chk("adr_queue_drained", 32'(q_adr.size()), 32'h0);
        chk("dat_queue_drained", 32'(q_dat.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
